// File: rtl/rt_stage_pkg.sv
// Shared retire-stage types: ROB head view, regfile write packet, FSM state.
// Imported by rt_select and rt_stage.
package rt_stage_pkg;

  localparam int XLEN = 32;
  localparam int RT_N = 2;

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic [4:0]      dest_reg_idx;
    logic            dest_reg_valid;
    logic [XLEN-1:0] value;
    logic            halt;
    logic            illegal;
    logic            mispredict;
    logic [XLEN-1:0] target_pc;
  } ROB_RT_PACKET;

  typedef struct packed {
    logic            valid;
    logic [4:0]      retire_reg;
    logic [XLEN-1:0] value;
  } RT_DP_PACKET;

  typedef enum logic [1:0] {
    RT_RUN,
    RT_FLUSH,
    RT_HALTED
  } RT_STATE;

endpackage

// File: rtl/rt_select.sv
// Combinational retire picker: in-order completed prefix, stop lane,
// and per-lane regfile write enables with duplicate-dest suppression.
module rt_select
  import rt_stage_pkg::*;
#(
  parameter  int RT_WIDTH = RT_N,
  localparam int PW = $clog2(RT_WIDTH + 1),
  localparam int LW = (RT_WIDTH > 1) ? $clog2(RT_WIDTH) : 1
) (
  input  logic              en,
  input  logic [RT_WIDTH-1:0] vld,
  input  logic [RT_WIDTH-1:0] cmp,
  input  logic [RT_WIDTH-1:0] dv,
  input  logic [RT_WIDTH-1:0][4:0] idx,
  input  logic [RT_WIDTH-1:0] hlt,
  input  logic [RT_WIDTH-1:0] ill,
  input  logic [RT_WIDTH-1:0] misp,
  output logic [RT_WIDTH-1:0] wr_valid,
  output logic [PW-1:0]       pop_cnt,
  output logic [LW-1:0]       stop_idx,
  output logic                stop_misp,
  output logic                stop_halt,
  output logic                stop_ill
);

  logic [RT_WIDTH-1:0] retire;
  logic                go;

  // Walk lanes oldest-first; a hole or a stopping lane ends the prefix.
  always_comb begin
    go        = en;
    retire    = '0;
    pop_cnt   = '0;
    stop_idx  = '0;
    stop_misp = 1'b0;
    stop_halt = 1'b0;
    stop_ill  = 1'b0;
    for (int i = 0; i < RT_WIDTH; i++) begin
      if (go && vld[i] && cmp[i]) begin
        retire[i] = 1'b1;
        pop_cnt   = pop_cnt + PW'(1);
        if (hlt[i] || ill[i] || misp[i]) begin
          go        = 1'b0;
          stop_idx  = LW'(i);
          stop_ill  = ill[i];
          stop_halt = hlt[i] | ill[i];
          stop_misp = misp[i] & ~hlt[i] & ~ill[i];
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  // Keep only the youngest writer of each architectural register.
  always_comb begin
    wr_valid = '0;
    for (int i = 0; i < RT_WIDTH; i++) begin
      wr_valid[i] = retire[i] && dv[i] && (idx[i] != 5'd0);
      for (int j = i + 1; j < RT_WIDTH; j++) begin
        if (retire[j] && dv[j] && (idx[j] == idx[i]))
          wr_valid[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rt_stage.sv
// In-order retire stage: commits the completed ROB prefix, issues regfile
// writes one cycle later, and owns the squash and halt/exception stop.
module rt_stage
  import rt_stage_pkg::*;
#(
  parameter  int RT_WIDTH = RT_N,
  parameter  int CNT_W = 64,
  localparam int PW = $clog2(RT_WIDTH + 1),
  localparam int LW = (RT_WIDTH > 1) ? $clog2(RT_WIDTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  ROB_RT_PACKET      rob_head [RT_WIDTH],
  output logic [PW-1:0]     rob_pop_cnt,
  output RT_DP_PACKET       rt_packet [RT_WIDTH],
  output logic              squash,
  output logic [XLEN-1:0]   squash_pc,
  output logic              halted,
  output logic              exception,
  output logic [CNT_W-1:0]  retired_count
);

  RT_STATE             state_q, state_d;
  RT_DP_PACKET         pkt_q [RT_WIDTH];
  RT_DP_PACKET         pkt_d [RT_WIDTH];
  logic                squash_q, squash_d;
  logic [XLEN-1:0]     squash_pc_q, squash_pc_d;
  logic                halted_q, halted_d;
  logic                exc_q, exc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [RT_WIDTH-1:0] vld, cmp, dv, hlt, ill, misp;
  logic [RT_WIDTH-1:0][4:0] idx;
  logic [RT_WIDTH-1:0] wr_valid;
  logic [PW-1:0]       pop_cnt;
  logic [LW-1:0]       stop_idx;
  logic                stop_misp, stop_halt, stop_ill;

  // Flatten the ROB head fields the picker needs.
  always_comb begin
    for (int i = 0; i < RT_WIDTH; i++) begin
      vld[i]  = rob_head[i].valid;
      cmp[i]  = rob_head[i].complete;
      dv[i]   = rob_head[i].dest_reg_valid;
      idx[i]  = rob_head[i].dest_reg_idx;
      hlt[i]  = rob_head[i].halt;
      ill[i]  = rob_head[i].illegal;
      misp[i] = rob_head[i].mispredict;
    end
  end

  rt_select #(
    .RT_WIDTH (RT_WIDTH)
  ) u_sel (
    .en        (state_q == RT_RUN),
    .vld       (vld),
    .cmp       (cmp),
    .dv        (dv),
    .idx       (idx),
    .hlt       (hlt),
    .ill       (ill),
    .misp      (misp),
    .wr_valid  (wr_valid),
    .pop_cnt   (pop_cnt),
    .stop_idx  (stop_idx),
    .stop_misp (stop_misp),
    .stop_halt (stop_halt),
    .stop_ill  (stop_ill)
  );

  assign rob_pop_cnt = reset ? '0 : pop_cnt;

  // Next-state: FSM transitions, write packets and commit counter.
  always_comb begin
    state_d     = state_q;
    squash_d    = 1'b0;
    squash_pc_d = squash_pc_q;
    halted_d    = halted_q;
    exc_d       = exc_q;
    cnt_d       = cnt_q + CNT_W'(pop_cnt);
    for (int i = 0; i < RT_WIDTH; i++) begin
      pkt_d[i].valid      = wr_valid[i];
      pkt_d[i].retire_reg = wr_valid[i] ? rob_head[i].dest_reg_idx : 5'd0;
      pkt_d[i].value      = wr_valid[i] ? rob_head[i].value : '0;
    end
    unique case (state_q)
      RT_RUN: begin
        if (stop_halt) begin
          state_d  = RT_HALTED;
          halted_d = 1'b1;
          exc_d    = stop_ill;
        end else if (stop_misp) begin
          state_d     = RT_FLUSH;
          squash_d    = 1'b1;
          squash_pc_d = rob_head[stop_idx].target_pc;
        end
      end
      RT_FLUSH:  state_d = RT_RUN;
      RT_HALTED: state_d = RT_HALTED;
      default:   state_d = RT_RUN;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RT_RUN;
      squash_q    <= 1'b0;
      squash_pc_q <= '0;
      halted_q    <= 1'b0;
      exc_q       <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < RT_WIDTH; i++)
        pkt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      squash_q    <= squash_d;
      squash_pc_q <= squash_pc_d;
      halted_q    <= halted_d;
      exc_q       <= exc_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < RT_WIDTH; i++)
        pkt_q[i] <= pkt_d[i];
    end
  end

  assign rt_packet     = pkt_q;
  assign squash        = squash_q;
  assign squash_pc     = squash_pc_q;
  assign halted        = halted_q;
  assign exception     = exc_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_rt_stage.sv
// Self-checking bench for rt_stage: directed scenarios plus randomized
// ROB heads checked against a behavioural retire model.
module tb_rt_stage;
  import rt_stage_pkg::*;

  localparam int N = 2;
  localparam int CW = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  ROB_RT_PACKET      head [N];
  logic [1:0]        pop;
  RT_DP_PACKET       pkt [N];
  logic              squash;
  logic [XLEN-1:0]   squash_pc;
  logic              halted;
  logic              exception;
  logic [CW-1:0]     count;

  int                passed = 0;
  int                total = 0;

  // model results
  int                e_pop;
  int                e_stop;
  logic [XLEN-1:0]   e_pc;
  RT_DP_PACKET       e_pkt [N];
  logic [CW-1:0]     m_cnt;

  always #5 clock = ~clock;

  rt_stage #(.RT_WIDTH(N), .CNT_W(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .rob_head      (head),
    .rob_pop_cnt   (pop),
    .rt_packet     (pkt),
    .squash        (squash),
    .squash_pc     (squash_pc),
    .halted        (halted),
    .exception     (exception),
    .retired_count (count)
  );

  function automatic ROB_RT_PACKET mk(bit v, bit c, int r, bit d,
                                      logic [XLEN-1:0] val, bit h,
                                      bit il, bit mp,
                                      logic [XLEN-1:0] pc);
    ROB_RT_PACKET p;
    p.valid = v; p.complete = c; p.dest_reg_idx = 5'(r);
    p.dest_reg_valid = d; p.value = val; p.halt = h;
    p.illegal = il; p.mispredict = mp; p.target_pc = pc;
    return p;
  endfunction

  // Behavioural retire rule: completed prefix, stop after a flagged
  // instruction, youngest writer of each register wins.
  function automatic void model_eval();
    bit seen [32];
    e_pop = 0; e_stop = 0; e_pc = '0;
    for (int i = 0; i < N; i++) begin
      if (!(head[i].valid && head[i].complete)) break;
      e_pop++;
      if (head[i].illegal) e_stop = 3;
      else if (head[i].halt) e_stop = 2;
      else if (head[i].mispredict) begin
        e_stop = 1; e_pc = head[i].target_pc;
      end
      if (e_stop != 0) break;
    end
    for (int r = 0; r < 32; r++) seen[r] = 1'b0;
    for (int i = 0; i < N; i++) e_pkt[i] = '0;
    for (int i = e_pop - 1; i >= 0; i--) begin
      if (head[i].dest_reg_valid && head[i].dest_reg_idx != 0 &&
          !seen[head[i].dest_reg_idx]) begin
        seen[head[i].dest_reg_idx] = 1'b1;
        e_pkt[i].valid = 1'b1;
        e_pkt[i].retire_reg = head[i].dest_reg_idx;
        e_pkt[i].value = head[i].value;
      end
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_heads();
    for (int i = 0; i < N; i++) head[i] = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++)
      head[i] = mk(1, 1, i + 1, 1, 32'h55, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (pop !== 2'd0 || pkt[0].valid !== 1'b0 || pkt[1].valid !== 1'b0
          || count !== '0 || squash !== 1'b0 || halted !== 1'b0) begin
        $display("FAIL reset: pop=%0d v0=%b v1=%b cnt=%0d sq=%b h=%b want 0s",
                 pop, pkt[0].valid, pkt[1].valid, count, squash, halted);
      end else passed++;
      step();
    end
    clear_heads();
    reset = 1'b0;
    m_cnt = '0;
  endtask

  task automatic test_basic();
    head[0] = mk(1, 1, 5, 1, 32'h11, 0, 0, 0, 0);
    head[1] = mk(1, 1, 6, 1, 32'h22, 0, 0, 0, 0);
    #1;
    total++;
    if (pop !== 2'd2) $display("FAIL basic_pop: got %0d want 2", pop);
    else passed++;
    step();
    clear_heads();
    m_cnt += 2;
    total++;
    if (pkt[0] !== RT_DP_PACKET'({1'b1, 5'd5, 32'h11}) ||
        pkt[1] !== RT_DP_PACKET'({1'b1, 5'd6, 32'h22}))
      $display("FAIL basic_pkt: got %h %h want (1,5,11) (1,6,22)",
               pkt[0], pkt[1]);
    else passed++;
    total++;
    if (count !== m_cnt) $display("FAIL basic_cnt: got %0d want %0d", count, m_cnt);
    else passed++;
  endtask

  task automatic test_hole();
    head[0] = mk(1, 0, 5, 1, 32'h1, 0, 0, 0, 0);
    head[1] = mk(1, 1, 6, 1, 32'h2, 0, 0, 0, 0);
    #1;
    total++;
    if (pop !== 2'd0) $display("FAIL hole_pop: got %0d want 0", pop);
    else passed++;
    step();
    total++;
    if (pkt[0].valid !== 1'b0 || pkt[1].valid !== 1'b0)
      $display("FAIL hole_pkt: got v=%b%b want 00", pkt[1].valid, pkt[0].valid);
    else passed++;
    head[0] = mk(1, 1, 0, 1, 32'h9, 0, 0, 0, 0);
    head[1] = '0;
    #1;
    total++;
    if (pop !== 2'd1) $display("FAIL x0_pop: got %0d want 1", pop);
    else passed++;
    step();
    clear_heads();
    m_cnt += 1;
    total++;
    if (pkt[0] !== '0 || count !== m_cnt)
      $display("FAIL x0_pkt: got %h cnt=%0d want 0 cnt=%0d", pkt[0], count, m_cnt);
    else passed++;
  endtask

  task automatic test_dup();
    head[0] = mk(1, 1, 7, 1, 32'hA, 0, 0, 0, 0);
    head[1] = mk(1, 1, 7, 1, 32'hB, 0, 0, 0, 0);
    step();
    clear_heads();
    m_cnt += 2;
    total++;
    if (pkt[0] !== '0 || pkt[1] !== RT_DP_PACKET'({1'b1, 5'd7, 32'hB}))
      $display("FAIL dup: got %h %h want 0 (1,7,B)", pkt[0], pkt[1]);
    else passed++;
  endtask

  task automatic test_mispredict();
    head[0] = mk(1, 1, 3, 1, 32'h5, 0, 0, 1, 32'h100);
    head[1] = mk(1, 1, 4, 1, 32'h6, 0, 0, 0, 0);
    #1;
    total++;
    if (pop !== 2'd1) $display("FAIL misp_pop: got %0d want 1", pop);
    else passed++;
    step();
    m_cnt += 1;
    total++;
    if (squash !== 1'b1 || squash_pc !== 32'h100 || pop !== 2'd0 ||
        pkt[0] !== RT_DP_PACKET'({1'b1, 5'd3, 32'h5}) || pkt[1].valid !== 1'b0)
      $display("FAIL misp_flush: sq=%b pc=%h pop=%0d p0=%h v1=%b want 1 100 0",
               squash, squash_pc, pop, pkt[0], pkt[1].valid);
    else passed++;
    step();
    total++;
    if (squash !== 1'b0 || pkt[0].valid !== 1'b0 || count !== m_cnt)
      $display("FAIL misp_after: sq=%b v0=%b cnt=%0d want 0 0 %0d",
               squash, pkt[0].valid, count, m_cnt);
    else passed++;
    head[0] = mk(1, 1, 4, 1, 32'h6, 0, 0, 0, 0);
    head[1] = '0;
    #1;
    total++;
    if (pop !== 2'd1) $display("FAIL misp_run: got %0d want 1", pop);
    else passed++;
    step();
    clear_heads();
    m_cnt += 1;
  endtask

  task automatic test_illegal();
    head[0] = mk(1, 1, 8, 1, 32'h80, 0, 0, 0, 0);
    head[1] = mk(1, 1, 9, 0, 32'h0, 0, 1, 1, 32'h200);
    #1;
    total++;
    if (pop !== 2'd2) $display("FAIL ill_pop: got %0d want 2", pop);
    else passed++;
    step();
    m_cnt += 2;
    total++;
    if (halted !== 1'b1 || exception !== 1'b1 || squash !== 1'b0 ||
        pkt[0] !== RT_DP_PACKET'({1'b1, 5'd8, 32'h80}))
      $display("FAIL ill_halt: h=%b e=%b sq=%b p0=%h want 1 1 0",
               halted, exception, squash, pkt[0]);
    else passed++;
    head[0] = mk(1, 1, 10, 1, 32'h1, 0, 0, 0, 0);
    head[1] = mk(1, 1, 11, 1, 32'h2, 0, 0, 0, 0);
    #1;
    total++;
    if (pop !== 2'd0) $display("FAIL halted_pop: got %0d want 0", pop);
    else passed++;
    step();
    total++;
    if (pkt[0].valid !== 1'b0 || pkt[1].valid !== 1'b0 ||
        count !== m_cnt || halted !== 1'b1)
      $display("FAIL halted_frz: v=%b%b cnt=%0d h=%b want 00 %0d 1",
               pkt[1].valid, pkt[0].valid, count, halted, m_cnt);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0 || exception !== 1'b0 || count !== '0 || pop !== 2'd0)
      $display("FAIL ill_reset: h=%b e=%b cnt=%0d pop=%0d want 0",
               halted, exception, count, pop);
    else passed++;
    clear_heads();
    #1;
    reset = 1'b0;
    m_cnt = '0;
  endtask

  task automatic test_random();
    int mode = 0;
    int bad = 0;
    logic exp_sq;
    logic exp_h;
    logic exp_e;
    logic [XLEN-1:0] exp_pc = '0;
    RT_DP_PACKET nx [N];
    exp_h = 1'b0; exp_e = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        head[i] = mk($urandom_range(99) < 85, $urandom_range(99) < 75,
                     $urandom_range(7), $urandom_range(1),
                     $urandom, $urandom_range(99) < 4,
                     $urandom_range(99) < 3, $urandom_range(99) < 10,
                     $urandom);
      end
      model_eval();
      if (mode != 0) e_pop = 0;
      #1;
      total++;
      if (pop !== 2'(e_pop)) begin
        bad++;
        $display("FAIL rnd_pop c=%0d: got %0d want %0d", c, pop, e_pop);
      end else passed++;
      exp_sq = 1'b0;
      for (int i = 0; i < N; i++) nx[i] = '0;
      if (mode == 0) begin
        for (int i = 0; i < N; i++) nx[i] = e_pkt[i];
        m_cnt += CW'(e_pop);
        if (e_stop >= 2) begin
          mode = 2; exp_h = 1'b1; exp_e = (e_stop == 3);
        end else if (e_stop == 1) begin
          mode = 1; exp_sq = 1'b1; exp_pc = e_pc;
        end
      end else if (mode == 1) begin
        mode = 0;
      end
      step();
      total++;
      if (pkt[0] !== nx[0] || pkt[1] !== nx[1] || squash !== exp_sq ||
          (exp_sq && squash_pc !== exp_pc) || halted !== exp_h ||
          exception !== exp_e || count !== m_cnt) begin
        bad++;
        $display("FAIL rnd_state c=%0d: pkt=%h/%h sq=%b pc=%h h=%b e=%b cnt=%0d want %h/%h %b %h %b %b %0d",
                 c, pkt[0], pkt[1], squash, squash_pc, halted, exception,
                 count, nx[0], nx[1], exp_sq, exp_pc, exp_h, exp_e, m_cnt);
      end else passed++;
      if (mode == 2 && $urandom_range(3) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        mode = 0; exp_h = 1'b0; exp_e = 1'b0; m_cnt = '0;
      end
      if (bad > 10) break;
    end
    clear_heads();
  endtask

  initial begin
    clear_heads();
    m_cnt = '0;
    test_reset();
    test_basic();
    test_hole();
    test_dup();
    test_mispredict();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
